// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM states, word-length
// encoding and the data-bit ordering/parity functions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    localparam logic [1:0] WORD_5 = 2'd0;
    localparam logic [1:0] WORD_6 = 2'd1;
    localparam logic [1:0] WORD_7 = 2'd2;
    localparam logic [1:0] WORD_8 = 2'd3;

    function automatic logic [3:0] word_len(input logic [1:0] w);
        logic [3:0] n;
        case (w)
            WORD_5:  n = 4'd5;
            WORD_6:  n = 4'd6;
            WORD_7:  n = 4'd7;
            WORD_8:  n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] word_mask(input logic [1:0] w);
        return 8'hFF >> (4'd8 - word_len(w));
    endfunction

    function automatic logic calc_parity(input logic [7:0] d, input logic [1:0] w,
                                         input logic odd);
        return (^(d & word_mask(w))) ^ odd;
    endfunction

    // Reverse the low N bits so an MSB-first word can leave through the same right shift.
    function automatic logic [7:0] msb_align(input logic [7:0] d, input logic [1:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = d[7-i];
        end
        return r >> (4'd8 - word_len(w));
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Word handshake and status between a producer and the UART transmitter.
interface uart_tx_if;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic       uart_tx_busy;
    logic       uart_tx_done_it;

    modport master (
        output uart_tx_data, uart_tx_valid,
        input  uart_tx_ready, uart_tx_busy, uart_tx_done_it
    );

    modport slave (
        input  uart_tx_data, uart_tx_valid,
        output uart_tx_ready, uart_tx_busy, uart_tx_done_it
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: one tick every max(div,1) cycles while running,
// realigned to the start of each frame.
module uart_baud_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] div,
    input  logic       run,
    input  logic       restart,
    output logic       tick
);

    logic [8:0] cnt_r;
    logic [8:0] last_s;

    // Terminal count of the bit period; a divider of zero behaves as one.
    always_comb begin
        if (div == 9'd0) begin
            last_s = 9'd0;
        end else begin
            last_s = div - 9'd1;
        end
    end

    assign tick = run & (cnt_r == last_s);

    // Cycle counter within the current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 9'd0;
        end else if (restart || !run || tick) begin
            cnt_r <= 9'd0;
        end else begin
            cnt_r <= cnt_r + 9'd1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-word holding register, per-frame configuration
// shadowing and a registered serial output.
module uart_tx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       atpg_rst_ctrl,
    input  logic [8:0] cfg_clk_div,
    input  logic       cfg_enable,
    input  logic       cfg_has_parity,
    input  logic       cfg_odd_parity,
    input  logic       cfg_extend_stop,
    input  logic       cfg_lsb_first,
    input  logic [1:0] cfg_word,
    uart_tx_if.slave   tx,
    output logic       ms_utx
);

    uart_state_e state_r, state_nx_s;
    logic       rst_s, run_s, tick_s, accept_s, start_s, frame_end_s, last_bit_s;
    logic [7:0] load_data_s;
    logic       hold_full_r, hold_full_nx_s;
    logic [7:0] hold_data_r;
    logic [7:0] shift_r, shift_nx_s;
    logic [3:0] bit_cnt_r, bit_cnt_nx_s;
    logic       par_r, par_nx_s;
    logic [8:0] div_r;
    logic       has_par_r, ext_stop_r;
    logic [1:0] word_r;
    logic       line_r, line_nx_s, busy_r, busy_nx_s, done_r, done_nx_s, ready_r, ready_nx_s;

    assign rst_s       = rst | atpg_rst_ctrl;
    assign run_s       = (state_r != ST_IDLE);
    assign accept_s    = tx.uart_tx_valid & ready_r & cfg_enable;
    assign frame_end_s = tick_s & (((state_r == ST_STOP1) & ~ext_stop_r) | (state_r == ST_STOP2));
    assign start_s     = cfg_enable & (((state_r == ST_IDLE) & accept_s)
                                     | (frame_end_s & (hold_full_r | accept_s)));
    assign load_data_s = hold_full_r ? hold_data_r : tx.uart_tx_data;
    assign last_bit_s  = (bit_cnt_r == (word_len(word_r) - 4'd1));

    uart_baud_gen u_baud (
        .clk     (clk),
        .rst     (rst_s),
        .div     (div_r),
        .run     (run_s),
        .restart (start_s),
        .tick    (tick_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state and shift-register advance; parity and bit order are fixed at load.
    always_comb begin
        state_nx_s   = state_r;
        shift_nx_s   = shift_r;
        bit_cnt_nx_s = bit_cnt_r;
        par_nx_s     = par_r;
        if (!cfg_enable) begin
            state_nx_s = ST_IDLE;
        end else if (start_s) begin
            state_nx_s   = ST_START;
            bit_cnt_nx_s = 4'd0;
            shift_nx_s   = cfg_lsb_first ? load_data_s : msb_align(load_data_s, cfg_word);
            par_nx_s     = calc_parity(load_data_s, cfg_word, cfg_odd_parity);
        end else if (tick_s) begin
            case (state_r)
                ST_START:  state_nx_s = ST_DATA;
                ST_DATA: begin
                    shift_nx_s   = {1'b0, shift_r[7:1]};
                    bit_cnt_nx_s = bit_cnt_r + 4'd1;
                    if (last_bit_s) begin
                        state_nx_s = has_par_r ? ST_PARITY : ST_STOP1;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end
                ST_PARITY: state_nx_s = ST_STOP1;
                ST_STOP1:  state_nx_s = ext_stop_r ? ST_STOP2 : ST_IDLE;
                ST_STOP2:  state_nx_s = ST_IDLE;
                default:   state_nx_s = ST_IDLE;
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Holding register occupancy; a disable empties it.
    always_comb begin
        hold_full_nx_s = hold_full_r;
        if (!cfg_enable) begin
            hold_full_nx_s = 1'b0;
        end else if (start_s && hold_full_r) begin
            hold_full_nx_s = 1'b0;
        end else if (accept_s && !start_s) begin
            hold_full_nx_s = 1'b1;
        end else begin
            hold_full_nx_s = hold_full_r;
        end
    end

    // Output decode from the next state so the line register lines up with the FSM.
    always_comb begin
        case (state_nx_s)
            ST_IDLE:   line_nx_s = 1'b1;
            ST_START:  line_nx_s = 1'b0;
            ST_DATA:   line_nx_s = shift_nx_s[0];
            ST_PARITY: line_nx_s = par_nx_s;
            ST_STOP1:  line_nx_s = 1'b1;
            ST_STOP2:  line_nx_s = 1'b1;
            default:   line_nx_s = 1'b1;
        endcase
        busy_nx_s  = (state_nx_s != ST_IDLE);
        done_nx_s  = frame_end_s & cfg_enable;
        ready_nx_s = cfg_enable & ~hold_full_nx_s;
    end

    // Datapath, holding register and configuration shadows.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            shift_r     <= 8'd0;
            bit_cnt_r   <= 4'd0;
            par_r       <= 1'b0;
            hold_full_r <= 1'b0;
            hold_data_r <= 8'd0;
            div_r       <= 9'd0;
            has_par_r   <= 1'b0;
            ext_stop_r  <= 1'b0;
            word_r      <= WORD_8;
        end else begin
            shift_r     <= shift_nx_s;
            bit_cnt_r   <= bit_cnt_nx_s;
            par_r       <= par_nx_s;
            hold_full_r <= hold_full_nx_s;
            if (accept_s && !start_s) begin
                hold_data_r <= tx.uart_tx_data;
            end else begin
                hold_data_r <= hold_data_r;
            end
            if (start_s) begin
                div_r      <= cfg_clk_div;
                has_par_r  <= cfg_has_parity;
                ext_stop_r <= cfg_extend_stop;
                word_r     <= cfg_word;
            end else begin
                div_r      <= div_r;
                has_par_r  <= has_par_r;
                ext_stop_r <= ext_stop_r;
                word_r     <= word_r;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            line_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            line_r  <= line_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
            ready_r <= ready_nx_s;
        end
    end

    assign ms_utx             = line_r;
    assign tx.uart_tx_busy    = busy_r;
    assign tx.uart_tx_done_it = done_r;
    assign tx.uart_tx_ready   = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx against a frame-level model that
// predicts the serial line, busy and done for every clock cycle.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst, atpg_rst_ctrl;
    logic [8:0] cfg_clk_div;
    logic       cfg_enable, cfg_has_parity, cfg_odd_parity, cfg_extend_stop, cfg_lsb_first;
    logic [1:0] cfg_word;
    logic       ms_utx;

    int vectors     = 0;
    int miscompares = 0;
    bit line_q[$];
    int ends_q[$];
    bit cap_q[$];

    always #5 clk = ~clk;

    uart_tx_if tx_if ();

    uart_tx dut (
        .clk             (clk),
        .rst             (rst),
        .atpg_rst_ctrl   (atpg_rst_ctrl),
        .cfg_clk_div     (cfg_clk_div),
        .cfg_enable      (cfg_enable),
        .cfg_has_parity  (cfg_has_parity),
        .cfg_odd_parity  (cfg_odd_parity),
        .cfg_extend_stop (cfg_extend_stop),
        .cfg_lsb_first   (cfg_lsb_first),
        .cfg_word        (cfg_word),
        .tx              (tx_if),
        .ms_utx          (ms_utx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Model: append one frame, each bit held for max(div,1) cycles, using the current cfg.
    task automatic push_frame(input logic [7:0] d);
        int n, div_eff, ones;
        bit bits[$];
        n       = 5 + int'(cfg_word);
        div_eff = (cfg_clk_div == 9'd0) ? 1 : int'(cfg_clk_div);
        ones    = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            ones += int'(d[i]);
            bits.push_back(cfg_lsb_first ? d[i] : d[n-1-i]);
        end
        if (cfg_has_parity) bits.push_back(((ones % 2) == 1) ^ cfg_odd_parity);
        bits.push_back(1'b1);
        if (cfg_extend_stop) bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int r = 0; r < div_eff; r++) line_q.push_back(bits[j]);
        end
        ends_q.push_back(line_q.size());
    endtask

    task automatic clear_model();
        line_q.delete();
        ends_q.delete();
    endtask

    task automatic send_word(input logic [7:0] d);
        int w = 0;
        while (tx_if.uart_tx_ready !== 1'b1 && w < 60) begin
            step();
            w++;
        end
        check_bit("ready_wait", tx_if.uart_tx_ready, 1'b1);
        tx_if.uart_tx_data  = d;
        tx_if.uart_tx_valid = 1'b1;
        step();
        tx_if.uart_tx_valid = 1'b0;
    endtask

    // Compare n_check consecutive cycles starting right after the accepting edge.
    task automatic run_check(input int n_check, input bit send2, input logic [7:0] d2);
        int total;
        bit exp_done;
        total = line_q.size();
        cap_q.delete();
        for (int k = 0; k < n_check; k++) begin
            exp_done = 1'b0;
            foreach (ends_q[i]) if (ends_q[i] == k) exp_done = 1'b1;
            check_bit($sformatf("line[%0d]", k), ms_utx, (k < total) ? line_q[k] : 1'b1);
            check_bit($sformatf("busy[%0d]", k), tx_if.uart_tx_busy, k < total);
            check_bit($sformatf("done[%0d]", k), tx_if.uart_tx_done_it, exp_done);
            cap_q.push_back(ms_utx);
            if (k == 0 && send2) begin
                check_bit("ready_b2b", tx_if.uart_tx_ready, 1'b1);
                tx_if.uart_tx_data  = d2;
                tx_if.uart_tx_valid = 1'b1;
                step();
                tx_if.uart_tx_valid = 1'b0;
            end else begin
                step();
            end
        end
    endtask

    // Independent receiver: sample mid-bit of an 8-bit LSB-first frame in the capture.
    function automatic logic [7:0] decode(input int base, input int div);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = cap_q[base + (1 + j) * div + div / 2];
        return b;
    endfunction

    task automatic set_cfg(input logic [8:0] div, input logic [1:0] w, input logic par,
                           input logic odd, input logic ext, input logic lsb);
        cfg_clk_div = div; cfg_word = w; cfg_has_parity = par;
        cfg_odd_parity = odd; cfg_extend_stop = ext; cfg_lsb_first = lsb;
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; atpg_rst_ctrl = 1'b0; cfg_enable = 1'b1;
        set_cfg(9'd4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_if.uart_tx_valid = 1'b0; tx_if.uart_tx_data = 8'd0;
        step(); step();
        check_bit("rst_line", ms_utx, 1'b1);
        check_bit("rst_busy", tx_if.uart_tx_busy, 1'b0);
        check_bit("rst_done", tx_if.uart_tx_done_it, 1'b0);
        check_bit("rst_ready", tx_if.uart_tx_ready, 1'b0);
        rst = 1'b0;
        step();
        check_bit("ready_after_rst", tx_if.uart_tx_ready, 1'b1);

        // 8N1 MSB-first 0xCA at 4 clocks per bit.
        clear_model(); push_frame(8'hCA); send_word(8'hCA);
        run_check(line_q.size() + 2, 1'b0, 8'h00);

        // Back-to-back LSB-first 0x53 then 0xCA, decoded by the bench receiver.
        set_cfg(9'd4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        clear_model(); push_frame(8'h53); push_frame(8'hCA); send_word(8'h53);
        run_check(line_q.size() + 2, 1'b1, 8'hCA);
        check_byte("rx_byte0", decode(0, 4), 8'h53);
        check_byte("rx_byte1", decode(40, 4), 8'hCA);

        // 7O2 MSB-first 0x41.
        set_cfg(9'd2, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        clear_model(); push_frame(8'h41); send_word(8'h41);
        run_check(line_q.size() + 2, 1'b0, 8'h00);

        // Divider 0, 5-bit word from 0xFF.
        set_cfg(9'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_model(); push_frame(8'hFF); send_word(8'hFF);
        run_check(line_q.size() + 2, 1'b0, 8'h00);

        // Random frames; cfg is scrambled after acceptance and must not disturb the frame.
        for (int it = 0; it < 8; it++) begin
            set_cfg(9'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
            d = 8'($urandom);
            clear_model(); push_frame(d); send_word(d);
            set_cfg(9'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom));
            run_check(line_q.size() + 2, 1'b0, 8'h00);
        end

        // Abort by disabling during the data bits.
        set_cfg(9'd4, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_model(); push_frame(8'h00); send_word(8'h00);
        run_check(10, 1'b0, 8'h00);
        cfg_enable = 1'b0;
        step();
        check_bit("abort_line", ms_utx, 1'b1);
        check_bit("abort_busy", tx_if.uart_tx_busy, 1'b0);
        check_bit("abort_ready", tx_if.uart_tx_ready, 1'b0);
        for (int k = 0; k < 40; k++) begin
            check_bit("abort_no_done", tx_if.uart_tx_done_it, 1'b0);
            step();
        end
        // A request while disabled is ignored.
        tx_if.uart_tx_data = 8'h00; tx_if.uart_tx_valid = 1'b1;
        step(); step();
        check_bit("dis_ignore_busy", tx_if.uart_tx_busy, 1'b0);
        check_bit("dis_ignore_line", ms_utx, 1'b1);
        tx_if.uart_tx_valid = 1'b0;
        cfg_enable = 1'b1;
        step();
        check_bit("reenable_ready", tx_if.uart_tx_ready, 1'b1);

        // Reset mid-frame, then a normal frame.
        clear_model(); push_frame(8'h00); send_word(8'h00);
        run_check(12, 1'b0, 8'h00);
        rst = 1'b1;
        step();
        check_bit("midrst_line", ms_utx, 1'b1);
        check_bit("midrst_busy", tx_if.uart_tx_busy, 1'b0);
        check_bit("midrst_done", tx_if.uart_tx_done_it, 1'b0);
        check_bit("midrst_ready", tx_if.uart_tx_ready, 1'b0);
        rst = 1'b0;
        step();
        check_bit("midrst_ready_rise", tx_if.uart_tx_ready, 1'b1);
        clear_model(); push_frame(8'hA5); send_word(8'hA5);
        run_check(line_q.size() + 2, 1'b0, 8'h00);

        // Test-mode reset override.
        atpg_rst_ctrl = 1'b1;
        step();
        check_bit("atpg_ready", tx_if.uart_tx_ready, 1'b0);
        check_bit("atpg_line", ms_utx, 1'b1);
        atpg_rst_ctrl = 1'b0;
        step();
        check_bit("atpg_release_ready", tx_if.uart_tx_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameters: none; all configuration is by port.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 atpg_rst_ctrl  input  1  test-mode reset override; when 1, reset is forced active.
REQ-005 cfg_clk_div  input  9  clocks per bit; 0 is treated as 1.
REQ-006 cfg_enable  input  1  transmitter enable.
REQ-007 cfg_has_parity  input  1  inserts a parity bit after the data bits.
REQ-008 cfg_odd_parity  input  1  1 = odd parity, 0 = even parity.
REQ-009 cfg_extend_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 cfg_lsb_first  input  1  1 = LSB first, 0 = MSB first.
REQ-011 cfg_word  input  2  word length: 0=5, 1=6, 2=7, 3=8 bits.
REQ-012 uart_tx_data  input  8  word to send; only the low N bits are used, with N set by cfg_word.
REQ-013 uart_tx_valid  input  1  request to send uart_tx_data.
REQ-014 uart_tx_ready  output  1  holding register empty; a word is accepted when valid and ready are both 1 on the same edge.
REQ-015 uart_tx_busy  output  1  a frame is on the line.
REQ-016 uart_tx_done_it  output  1  one-cycle pulse when the last stop bit completes.
REQ-017 ms_utx  output  1  serial line; idles high.

Function
REQ-018 The frame SHALL be sent in this order: start bit (0), N data bits, optional parity bit, then 1 or 2 stop bits (1).
REQ-019 Each bit SHALL last exactly max(cfg_clk_div,1) clk cycles.
REQ-020 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2; START SHALL be entered on the cycle after a word is accepted.
REQ-021 State transitions: DATA goes to PARITY if cfg_has_parity, else to STOP1; STOP1 goes to STOP2 if cfg_extend_stop, else to IDLE (or START if the holding register is full); STOP2 goes to IDLE or START.
REQ-022 All cfg_* fields except cfg_enable SHALL be captured into shadow registers when entering START; changes during a frame SHALL not affect it.
REQ-023 Parity SHALL be the XOR of the N data bits, inverted when cfg_odd_parity is 1.
REQ-024 For MSB-first with N<8, bit N-1 SHALL be sent first.
REQ-025 A one-entry holding register SHALL allow back-to-back frames: the next start bit immediately follows the last stop bit, with zero idle cycles.
REQ-026 uart_tx_ready SHALL be 1 when the holding register is empty and cfg_enable is 1; when uart_tx_valid is 1 and uart_tx_ready is 0, the word SHALL be ignored.
REQ-027 Deasserting cfg_enable mid-frame SHALL abort the frame as follows:
- ms_utx returns to 1 on the next cycle;
- the FSM goes to IDLE;
- the holding register is cleared;
- no done pulse is issued.
REQ-028 If acceptance and a frame end occur on the same cycle, the frame SHALL still end, and the newly accepted word SHALL be sent next.
REQ-029 ms_utx SHALL be registered, with no combinational path from inputs.

Reset
REQ-030 In reset, the block SHALL be in this state: FSM in IDLE, ms_utx=1, uart_tx_busy=0, uart_tx_done_it=0, uart_tx_ready=0, holding register empty, counters 0.
REQ-031 Reset asserted mid-frame SHALL drive ms_utx to 1 on the following edge and discard the frame.
REQ-032 uart_tx_ready SHALL rise on the first cycle after reset if cfg_enable=1.

Structure
REQ-033 Package uart_pkg SHALL hold:
- the FSM state enum;
- the cfg_word encoding constants;
- a function mapping cfg_word to N.
REQ-034 Sub-module uart_baud_gen SHALL provide a per-bit tick from cfg_clk_div, with restart on frame start.
REQ-035 The parity bit and shift register SHALL be implemented in uart_tx; the block SHALL stay within 120-400 RTL lines.

Verification
REQ-036 Scenario: 8N1, MSB-first, cfg_clk_div=4, send 8'hCA -> ms_utx carries 0,1,1,0,0,1,0,1,0,1, each bit 4 cycles; done pulse at cycle 40.
REQ-037 Scenario: same settings, LSB-first, send 8'h53 then 8'hCA back-to-back -> 20 contiguous bits with no idle gap; both bytes are received correctly by the uart receiver in loopback.
REQ-038 Scenario: 7 bits, odd parity, two stop bits, send 8'h41 -> 1 start bit, bits 1000001, parity bit 1 (two ones, odd parity), then 2 stop bits; frame is 11 bits.
REQ-039 Scenario: cfg_clk_div=0 -> 1-cycle bits; 5-bit word 8'hFF -> low 5 bits all 1; frame is 7 cycles.
REQ-040 Scenario: cfg_enable cleared during DATA -> ms_utx=1 on the next cycle; busy falls; no done pulse.
REQ-041 Scenario: rst asserted mid-frame -> all outputs at reset values on the next edge; a new send after reset completes normally.
